// File: rtl/tank_mode_sequencer_if.sv
// Bundle between the tank mode sequencer and its neighbours: control and sensor inputs, mux-select outputs.
// No latency of its own; carries plain wires only.
// No backpressure: every signal is a level sampled on each CLK edge.  TANK_SEQ_FAULT_CODE_EN adds fault_code.
interface tank_mode_sequencer_if;
  logic       enable;
  logic       advance;
  logic       clear_err;
  logic [7:0] Q_tank_cleanliness;
  logic [7:0] Q_tank_temperature;
  logic [7:0] Q_tank_food_storage;
  logic [7:0] Q_tank_saltiness;
  logic [4:0] select;
  logic [7:0] scan_count;
  logic       err_flag;
`ifdef TANK_SEQ_FAULT_CODE_EN
  logic [3:0] fault_code;
`endif

  // Controller / stimulus side
  modport master (
    output enable, advance, clear_err,
    output Q_tank_cleanliness, Q_tank_temperature, Q_tank_food_storage, Q_tank_saltiness,
    input  select, scan_count, err_flag
`ifdef TANK_SEQ_FAULT_CODE_EN
    , input fault_code
`endif
  );

  // Sequencer side
  modport slave (
    input  enable, advance, clear_err,
    input  Q_tank_cleanliness, Q_tank_temperature, Q_tank_food_storage, Q_tank_saltiness,
    output select, scan_count, err_flag
`ifdef TANK_SEQ_FAULT_CODE_EN
    , output fault_code
`endif
  );
endinterface

// File: rtl/tank_mode_sequencer.sv
// Cycles the aquarium display mux through its modes and forces error mode on a persistent out-of-range reading.
// Outputs are registered: select/err_flag/scan_count change on the same edge as the internal state.
// No backpressure; manual steps come from rising edges of advance.  Optional TANK_SEQ_FAULT_CODE_EN adds fault_code.
module tank_mode_sequencer #(
  parameter int unsigned DWELL       = 16,
  parameter int unsigned ERR_PERSIST = 3,
  parameter logic [7:0]  CLEAN_MIN   = 8'd32,
  parameter logic [7:0]  TEMP_MIN    = 8'd20,
  parameter logic [7:0]  TEMP_MAX    = 8'd30,
  parameter logic [7:0]  FOOD_MIN    = 8'd8,
  parameter logic [7:0]  SALT_MIN    = 8'd10,
  parameter logic [7:0]  SALT_MAX    = 8'd40
) (
  input logic                  CLK,
  input logic                  reset,
  tank_mode_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_CLEAN = 3'd2;
  localparam logic [2:0] S_TEMP  = 3'd3;
  localparam logic [2:0] S_FOOD  = 3'd4;
  localparam logic [2:0] S_SALT  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [7:0] DWELL_LAST  = 8'(DWELL - 1);
  localparam logic [3:0] PERSIST_LIM = 4'(ERR_PERSIST);

  logic [2:0] state_q, state_d;
  logic [7:0] dwell_q, dwell_d;
  logic [3:0] persist_q, persist_d;
  logic [7:0] scan_q, scan_d;
  logic       adv_q;
  logic [4:0] select_q;
  logic       err_q;
`ifdef TANK_SEQ_FAULT_CODE_EN
  logic [3:0] fault_q, fault_d;
`endif

  logic [3:0] viol;
  logic       any_viol;
  logic       scanning;
  logic       adv_edge;
  logic [3:0] persist_inc;
  logic       err_hit;

  // Mux select code shown for each state
  function automatic logic [4:0] sel_code(input logic [2:0] s);
    case (s)
      S_COUNT: sel_code = 5'b00001;
      S_CLEAN: sel_code = 5'b00010;
      S_TEMP:  sel_code = 5'b00100;
      S_FOOD:  sel_code = 5'b01000;
      S_SALT:  sel_code = 5'b10000;
      S_ERROR: sel_code = 5'b11111;
      default: sel_code = 5'b00000;
    endcase
  endfunction

  // Per-sensor limit violations; values equal to a limit are in range
  assign viol[0] = bus.Q_tank_cleanliness < CLEAN_MIN;
  assign viol[1] = (bus.Q_tank_temperature < TEMP_MIN) || (bus.Q_tank_temperature > TEMP_MAX);
  assign viol[2] = bus.Q_tank_food_storage < FOOD_MIN;
  assign viol[3] = (bus.Q_tank_saltiness < SALT_MIN) || (bus.Q_tank_saltiness > SALT_MAX);
  assign any_viol = |viol;

  assign scanning    = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign adv_edge    = bus.advance & ~adv_q;
  assign persist_inc = persist_q + 4'd1;
  // Range check only runs while actively scanning with enable high
  assign err_hit     = bus.enable && scanning && any_viol && (persist_inc == PERSIST_LIM);

  // Next-state logic: error entry beats enable low, which beats dwell/manual advance
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    persist_d = persist_q;
    scan_d    = scan_q;
`ifdef TANK_SEQ_FAULT_CODE_EN
    fault_d   = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        dwell_d   = 8'd0;
        persist_d = 4'd0;
        if (bus.enable) state_d = S_COUNT;
      end
      S_ERROR: begin
        persist_d = 4'd0;
        if (bus.clear_err && !any_viol) begin
          state_d = S_IDLE;
          dwell_d = 8'd0;
`ifdef TANK_SEQ_FAULT_CODE_EN
          fault_d = 4'd0;
`endif
        end
      end
      S_COUNT, S_CLEAN, S_TEMP, S_FOOD, S_SALT: begin
        if (err_hit) begin
          state_d   = S_ERROR;
          dwell_d   = 8'd0;
          persist_d = 4'd0;
`ifdef TANK_SEQ_FAULT_CODE_EN
          fault_d   = viol;
`endif
        end else if (!bus.enable) begin
          state_d   = S_IDLE;
          dwell_d   = 8'd0;
          persist_d = 4'd0;
        end else begin
          persist_d = any_viol ? persist_inc : 4'd0;
          if ((dwell_q == DWELL_LAST) || adv_edge) begin
            dwell_d = 8'd0;
            if (state_q == S_SALT) begin
              state_d = S_COUNT;
              if (scan_q != 8'hFF) scan_d = scan_q + 8'd1;
            end else begin
              state_d = state_q + 3'd1;
            end
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        dwell_d   = 8'd0;
        persist_d = 4'd0;
      end
    endcase
  end

  // State, counters and registered outputs all update together on CLK
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dwell_q   <= 8'd0;
      persist_q <= 4'd0;
      scan_q    <= 8'd0;
      adv_q     <= 1'b0;
      select_q  <= 5'b00000;
      err_q     <= 1'b0;
`ifdef TANK_SEQ_FAULT_CODE_EN
      fault_q   <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      persist_q <= persist_d;
      scan_q    <= scan_d;
      adv_q     <= bus.advance;
      select_q  <= sel_code(state_d);
      err_q     <= (state_d == S_ERROR);
`ifdef TANK_SEQ_FAULT_CODE_EN
      fault_q   <= fault_d;
`endif
    end
  end

  assign bus.select     = select_q;
  assign bus.scan_count = scan_q;
  assign bus.err_flag   = err_q;
`ifdef TANK_SEQ_FAULT_CODE_EN
  assign bus.fault_code = fault_q;
`endif

endmodule

// File: tb/tb_tank_mode_sequencer.sv
// Bench for tank_mode_sequencer: directed scenarios then random stimulus, checked each cycle against a reference model.
// Model state is updated on every rising edge; DUT outputs are sampled 1 time unit later.
// No backpressure involved; inputs change just after each rising edge.
module tb_tank_mode_sequencer;
  localparam int DWELL   = 4;
  localparam int PERSIST = 3;

  logic CLK = 1'b0;
  logic reset;
  tank_mode_sequencer_if bus();

  tank_mode_sequencer #(.DWELL(DWELL), .ERR_PERSIST(PERSIST)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1..5 count/clean/temp/food/salt, 6 error
  int unsigned codes [7] = '{0, 1, 2, 4, 8, 16, 31};
  int       m_mode, m_held, m_run, m_scans;
  bit       m_adv_prev;
  bit [3:0] m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [3:0] sensor_bad(int c, int t, int f, int s);
    sensor_bad[0] = c < 32;
    sensor_bad[1] = (t < 20) || (t > 30);
    sensor_bad[2] = f < 8;
    sensor_bad[3] = (s < 10) || (s > 40);
  endfunction

  task automatic model_step();
    bit [3:0] bad;
    bit       edge_seen;
    bad = sensor_bad(bus.Q_tank_cleanliness, bus.Q_tank_temperature,
                     bus.Q_tank_food_storage, bus.Q_tank_saltiness);
    edge_seen = bus.advance && !m_adv_prev;
    if (reset) begin
      m_mode = 0; m_held = 0; m_run = 0; m_scans = 0; m_fault = 0;
    end else if (m_mode == 6) begin
      if (bus.clear_err && bad == 0) begin
        m_mode = 0; m_held = 0; m_fault = 0;
      end
    end else if (m_mode == 0) begin
      if (bus.enable) begin
        m_mode = 1; m_held = 0;
      end
    end else if (bus.enable && bad != 0 && m_run + 1 >= PERSIST) begin
      m_mode = 6; m_held = 0; m_run = 0; m_fault = bad;
    end else if (!bus.enable) begin
      m_mode = 0; m_held = 0; m_run = 0;
    end else begin
      m_run  = (bad != 0) ? m_run + 1 : 0;
      m_held = m_held + 1;
      if (m_held == DWELL || edge_seen) begin
        m_held = 0;
        if (m_mode == 5) begin
          m_mode = 1;
          if (m_scans < 255) m_scans++;
        end else begin
          m_mode++;
        end
      end
    end
    m_adv_prev = reset ? 1'b0 : bus.advance;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    chk("select", bus.select, codes[m_mode]);
    chk("err_flag", bus.err_flag, (m_mode == 6));
    chk("scan_count", bus.scan_count, m_scans);
`ifdef TANK_SEQ_FAULT_CODE_EN
    chk("fault_code", bus.fault_code, m_fault);
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_sensors(input int c, input int t, input int f, input int s);
    bus.Q_tank_cleanliness  = 8'(c);
    bus.Q_tank_temperature  = 8'(t);
    bus.Q_tank_food_storage = 8'(f);
    bus.Q_tank_saltiness    = 8'(s);
  endtask

  function automatic int pick(int lo, int hi);
    if ($urandom_range(0, 99) < 8) return int'($urandom_range(0, 255));
    return int'($urandom_range(hi, lo));
  endfunction

  int  saved_scans;
  bit  reached;

  initial begin
    m_mode = 0; m_held = 0; m_run = 0; m_scans = 0; m_fault = 0; m_adv_prev = 0;
    reset = 1'b1;
    bus.enable = 1'b0; bus.advance = 1'b0; bus.clear_err = 1'b0;
    set_sensors(50, 25, 20, 25);
    ticks(2);
    chk("rst_select", bus.select, 0);
    chk("rst_err", bus.err_flag, 0);
    chk("rst_scans", bus.scan_count, 0);

    // One full scan on dwell alone
    reset = 1'b0;
    bus.enable = 1'b1;
    ticks(21);
    chk("t1_select", bus.select, 1);
    chk("t1_scans", bus.scan_count, 1);

    // Held advance level gives one step out of CLEAN
    ticks(4);
    chk("t2_in_clean", bus.select, 2);
    bus.advance = 1'b1;
    ticks(3);
    chk("t2_one_step", bus.select, 4);
    bus.advance = 1'b0;
    tick();
    chk("t2_dwell_restart", bus.select, 4);

    // Short violation burst is tolerated, sustained one is not
    bus.Q_tank_temperature = 8'd35;
    ticks(2);
    bus.Q_tank_temperature = 8'd25;
    tick();
    chk("t3_no_err", bus.err_flag, 0);
    bus.Q_tank_temperature = 8'd35;
    ticks(3);
    chk("t3_err_select", bus.select, 31);
    chk("t3_err_flag", bus.err_flag, 1);

    // Clear only takes effect once inputs are back in range (30 is the limit itself)
    bus.clear_err = 1'b1;
    ticks(2);
    chk("t4_stay_err", bus.select, 31);
    bus.Q_tank_temperature = 8'd30;
    tick();
    chk("t4_exit_select", bus.select, 0);
    chk("t4_exit_err", bus.err_flag, 0);
    bus.clear_err = 1'b0;

    // Enable low mid-FOOD keeps the scan count
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      if (bus.select == 5'b01000) reached = 1;
    end
    chk("t5_reach_food", reached, 1);
    saved_scans = m_scans;
    bus.enable = 1'b0;
    tick();
    chk("t5_idle", bus.select, 0);
    chk("t5_scans_kept", bus.scan_count, saved_scans);

    // Reset wins while in ERROR
    bus.enable = 1'b1;
    bus.Q_tank_temperature = 8'd35;
    ticks(4);
    chk("t5_err", bus.err_flag, 1);
    reset = 1'b1;
    tick();
    chk("t5_rst_select", bus.select, 0);
    chk("t5_rst_err", bus.err_flag, 0);
    chk("t5_rst_scans", bus.scan_count, 0);
    reset = 1'b0;
    bus.Q_tank_temperature = 8'd25;

    // 260 scans saturate the counter
    ticks(1 + 260 * 5 * DWELL);
    chk("t6_saturate", bus.scan_count, 255);

`ifdef TANK_SEQ_FAULT_CODE_EN
    set_sensors(10, 25, 20, 50);
    ticks(3);
    chk("t6_fault_err", bus.err_flag, 1);
    chk("t6_fault_code", bus.fault_code, 4'b1001);
    set_sensors(50, 25, 20, 25);
    bus.clear_err = 1'b1;
    tick();
    chk("t6_fault_clr", bus.fault_code, 0);
    bus.clear_err = 1'b0;
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 299) == 0);
      bus.enable    = ($urandom_range(0, 19) != 0);
      bus.advance   = ($urandom_range(0, 3) == 0);
      bus.clear_err = ($urandom_range(0, 3) == 0);
      set_sensors(pick(32, 255), pick(20, 30), pick(8, 255), pick(10, 40));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
